// File: rtl/counter_pkg.sv
// Shared definitions for the mode-selectable up/down counters: the 2-bit
// mode encoding, the modulus maximum for each mode and the FSM state codes.
package counter_pkg;

  // Mode encoding (identical for the up- and down-counter)
  localparam logic [1:0] MODE_9  = 2'b00;
  localparam logic [1:0] MODE_11 = 2'b01;
  localparam logic [1:0] MODE_13 = 2'b10;
  localparam logic [1:0] MODE_15 = 2'b11;

  // Maximum count reached in each mode
  localparam int unsigned MAX_9  = 9;
  localparam int unsigned MAX_11 = 11;
  localparam int unsigned MAX_13 = 13;
  localparam int unsigned MAX_15 = 15;

  // FSM state codes
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Maximum count for a given mode
  function automatic int unsigned mode_max(input logic [1:0] mode);
    int unsigned m;
    m = MAX_9;
    case (mode)
      MODE_9:  m = MAX_9;
      MODE_11: m = MAX_11;
      MODE_13: m = MAX_13;
      MODE_15: m = MAX_15;
      default: m = MAX_9;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mode_down_counter_if.sv
// Control/status bundle of the mode down-counter. The master drives the
// controls and observes the count; the counter itself is the slave.
interface mode_down_counter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       mode;
  logic             start;
  logic             en;
  logic             oneshot;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic             done;
  logic             zero;

  modport master (
    output mode, start, en, oneshot,
    input  out, borrow, done, zero
  );

  modport slave (
    input  mode, start, en, oneshot,
    output out, borrow, done, zero
  );
endinterface

// File: rtl/counter_mode_decode.sv
// Combinational mode -> maximum count decoder, shared by the up- and
// down-counters so both agree on the moduli.
module counter_mode_decode
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_max
);

  // Translate the mode into its maximum count at the counter width
  always_comb begin
    o_max = WIDTH'(mode_max(i_mode));
  end

endmodule

// File: rtl/mode_down_counter.sv
// Programmable modulo down-counter. start loads the mode's maximum and
// enters RUN; each enabled cycle decrements. At zero it either wraps to the
// maximum (continuous) or halts in DONE (one-shot), pulsing borrow either way.
module mode_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  mode_down_counter_if.slave  bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_borrow;
  logic             r_done;
  logic [WIDTH-1:0] w_max;

  counter_mode_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .i_mode (bus.mode),
    .o_max  (w_max)
  );

  // State, count, borrow and done registers with prioritised next-state rules
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_out    <= '0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.start) begin
      r_state  <= ST_RUN;
      r_out    <= w_max;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_borrow <= 1'b0;
      if (bus.en) begin
        if (r_out > w_max) begin
          // Mode was lowered under a larger count: clamp without a borrow
          r_out <= w_max;
        end else if (r_out == '0) begin
          r_borrow <= 1'b1;
          if (bus.oneshot) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_out <= w_max;
          end
        end else begin
          r_out <= r_out - 1'b1;
        end
      end
    end else begin
      // IDLE or DONE: hold everything, only the borrow pulse ends
      r_borrow <= 1'b0;
    end
  end

  assign bus.out    = r_out;
  assign bus.borrow = r_borrow;
  assign bus.done   = r_done;
  assign bus.zero   = (r_out == '0);

endmodule
